// File: rtl/core_pkg.sv
// Shared core definitions: access-width encodings, memory-stage FSM states
// and the MEM/WB pipeline bundle.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] W_ILL  = 2'b00;
  localparam logic [1:0] W_BYTE = 2'b01;
  localparam logic [1:0] W_HALF = 2'b10;
  localparam logic [1:0] W_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [XLEN-1:0] op_c;
    logic [4:0]      reg_waddr;
    logic            reg_we;
    logic            mtype;
    logic [1:0]      width;
  } memwb_t;

  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/mem_store_align.sv
// Store lane replication, byte-strobe generation and alignment check for
// one memory access, purely combinational.
module mem_store_align
  import core_pkg::*;
(
  input  logic [1:0]      width,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic            misalign
);

  always_comb begin
    wdata    = data;
    wstrb    = 4'b0000;
    misalign = 1'b0;
    case (width)
      W_BYTE: begin
        wdata = {4{data[7:0]}};
        wstrb = 4'b0001 << addr;
      end
      W_HALF: begin
        wdata    = {2{data[15:0]}};
        wstrb    = 4'b0011 << addr;
        misalign = addr[0];
      end
      W_WORD: begin
        wstrb    = 4'b1111;
        misalign = |addr;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues Dcache requests, keeps an outstanding request
// stable across stalls and flushes, and registers the memwb bundle for WB.
module mem_stage
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            exmem_valid_i,
  input  logic [XLEN-1:0] exmem_op_c_i,
  input  logic [XLEN-1:0] exmem_store_data_i,
  input  logic [4:0]      exmem_reg_waddr_i,
  input  logic            exmem_reg_we_i,
  input  logic            exmem_mtype_i,
  input  logic            exmem_we_i,
  input  logic [1:0]      exmem_width_i,
  output logic            Dcache_req_o,
  output logic            Dcache_we_o,
  output logic [XLEN-1:0] Dcache_addr_o,
  output logic [XLEN-1:0] Dcache_wdata_o,
  output logic [3:0]      Dcache_wstrb_o,
  input  logic            Dcache_ready_i,
  output logic            mem_stall_o,
  output logic            misalign_o,
  input  logic            fc_flush_mem_i,
  input  logic            fc_bk_mem_i,
  output logic [XLEN-1:0] memwb_op_c_o,
  output logic [4:0]      memwb_reg_waddr_o,
  output logic            memwb_reg_we_o,
  output logic            memwb_mtype_o,
  output logic [1:0]      memwb_width_o,
  output mem_state_e      mem_state_o
);

  // Dcache handshake: a transfer happens on a rising edge where req and
  // ready are both high; once req rises, req/we/addr/wdata/wstrb stay
  // constant until that transfer (bk and rst are the only ways to drop it).

  mem_state_e      state;
  memwb_t          memwb_q;
  memwb_t          instr;
  logic [XLEN-1:0] lat_addr, lat_wdata;
  logic [3:0]      lat_wstrb;
  logic            lat_we;
  logic            misalign_q;

  logic [XLEN-1:0] al_wdata;
  logic [3:0]      al_wstrb;
  logic            al_misalign;
  logic            mem_op, eligible, req_raw, accept, capture;

  mem_store_align u_align (
    .width    (exmem_width_i),
    .addr     (exmem_op_c_i[1:0]),
    .data     (exmem_store_data_i),
    .wdata    (al_wdata),
    .wstrb    (al_wstrb),
    .misalign (al_misalign)
  );

  assign mem_op   = exmem_valid_i & exmem_mtype_i;
  assign eligible = mem_op & ~al_misalign;

  always_comb begin
    req_raw        = 1'b1;
    Dcache_we_o    = lat_we;
    Dcache_addr_o  = lat_addr;
    Dcache_wdata_o = lat_wdata;
    Dcache_wstrb_o = lat_wstrb;
    if (state == IDLE) begin
      req_raw        = eligible;
      Dcache_we_o    = exmem_we_i;
      Dcache_addr_o  = exmem_op_c_i;
      Dcache_wdata_o = al_wdata;
      Dcache_wstrb_o = exmem_we_i ? al_wstrb : 4'b0000;
    end
  end

  assign Dcache_req_o = req_raw & ~fc_bk_mem_i & ~rst;
  assign accept       = Dcache_req_o & Dcache_ready_i;
  assign mem_stall_o  = Dcache_req_o & ~Dcache_ready_i;

  assign instr = '{op_c:      exmem_op_c_i,
                   reg_waddr: exmem_reg_waddr_i,
                   reg_we:    exmem_reg_we_i,
                   mtype:     exmem_mtype_i,
                   width:     exmem_width_i};

  // A drained request never reaches WB; stalled cycles feed WB bubbles.
  assign capture = ~fc_flush_mem_i &
                   ((state == IDLE & exmem_valid_i & ~exmem_mtype_i) |
                    (state != DRAIN & accept));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      memwb_q    <= MEMWB_BUBBLE;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wstrb  <= '0;
      lat_we     <= 1'b0;
      misalign_q <= 1'b0;
    end else if (fc_bk_mem_i) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= (state == IDLE) & mem_op & al_misalign & ~fc_flush_mem_i;
      memwb_q    <= capture ? instr : MEMWB_BUBBLE;
      case (state)
        IDLE: begin
          if (mem_stall_o) begin
            lat_addr  <= Dcache_addr_o;
            lat_wdata <= Dcache_wdata_o;
            lat_wstrb <= Dcache_wstrb_o;
            lat_we    <= Dcache_we_o;
            state     <= fc_flush_mem_i ? DRAIN : WAIT;
          end
        end
        WAIT: begin
          if (accept)              state <= IDLE;
          else if (fc_flush_mem_i) state <= DRAIN;
        end
        DRAIN: if (accept) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign misalign_o        = misalign_q;
  assign memwb_op_c_o      = memwb_q.op_c;
  assign memwb_reg_waddr_o = memwb_q.reg_waddr;
  assign memwb_reg_we_o    = memwb_q.reg_we;
  assign memwb_mtype_o     = memwb_q.mtype;
  assign memwb_width_o     = memwb_q.width;
  assign mem_state_o       = state;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random traffic, all checked
// against a transaction-level model of the memory stage.
module tb_mem_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_reg_we, ex_mtype, ex_we;
  logic [31:0] ex_op_c, ex_sdata;
  logic [4:0]  ex_waddr;
  logic [1:0]  ex_width;
  logic        req, dc_we, ready, stall, mis, flush, bk;
  logic [31:0] dc_addr, dc_wdata;
  logic [3:0]  dc_wstrb;
  logic [31:0] wb_op_c;
  logic [4:0]  wb_waddr;
  logic        wb_reg_we, wb_mtype;
  logic [1:0]  wb_width;
  mem_state_e  st;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .exmem_valid_i(ex_valid), .exmem_op_c_i(ex_op_c), .exmem_store_data_i(ex_sdata),
    .exmem_reg_waddr_i(ex_waddr), .exmem_reg_we_i(ex_reg_we), .exmem_mtype_i(ex_mtype),
    .exmem_we_i(ex_we), .exmem_width_i(ex_width),
    .Dcache_req_o(req), .Dcache_we_o(dc_we), .Dcache_addr_o(dc_addr),
    .Dcache_wdata_o(dc_wdata), .Dcache_wstrb_o(dc_wstrb), .Dcache_ready_i(ready),
    .mem_stall_o(stall), .misalign_o(mis),
    .fc_flush_mem_i(flush), .fc_bk_mem_i(bk),
    .memwb_op_c_o(wb_op_c), .memwb_reg_waddr_o(wb_waddr), .memwb_reg_we_o(wb_reg_we),
    .memwb_mtype_o(wb_mtype), .memwb_width_o(wb_width), .mem_state_o(st)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: at most one outstanding request, plus expected WB view.
  logic        m_pend, m_drop, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] e_op;
  logic [4:0]  e_wa;
  logic        e_rwe, e_mt, e_mis;
  logic [1:0]  e_w;
  logic        prev_bk;

  function automatic int size_of(input logic [1:0] w);
    case (w)
      2'd1: return 1;
      2'd2: return 2;
      2'd3: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic aligned(input logic [31:0] a, input logic [1:0] w);
    int s = size_of(w);
    return (s != 0) && ((a % s) == 0);
  endfunction

  function automatic logic [31:0] rep(input logic [31:0] d, input logic [1:0] w);
    if (w == 2'd1) return {24'b0, d[7:0]} * 32'h0101_0101;
    if (w == 2'd2) return {16'b0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] strb(input logic [31:0] a, input logic [1:0] w);
    int m = ((1 << size_of(w)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  task automatic model_reset();
    m_pend = 0; m_drop = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
    e_op = 0; e_wa = 0; e_rwe = 0; e_mt = 0; e_w = 0; e_mis = 0; prev_bk = 0;
  endtask

  task automatic drive(input logic v, input logic mt, input logic we, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] wa,
                       input logic rwe);
    ex_valid = v; ex_mtype = mt; ex_we = we; ex_width = w;
    ex_op_c = a; ex_sdata = d; ex_waddr = wa; ex_reg_we = rwe;
  endtask

  // Check the current cycle at the falling edge, then advance the model.
  task automatic step();
    logic        x_req, x_we, mem, ok, acc, cap;
    logic [31:0] x_a, x_d;
    logic [3:0]  x_s;
    logic [1:0]  x_st;
    @(negedge clk);
    mem = ex_valid & ex_mtype;
    ok  = aligned(ex_op_c, ex_width);
    if (m_pend) begin
      x_req = !bk; x_a = m_addr; x_d = m_wdata; x_s = m_wstrb; x_we = m_we;
    end else begin
      x_req = mem & ok & !bk; x_a = ex_op_c; x_d = rep(ex_sdata, ex_width);
      x_s = ex_we ? strb(ex_op_c, ex_width) : 4'b0000; x_we = ex_we;
    end
    x_st = m_pend ? (m_drop ? 2'd2 : 2'd1) : 2'd0;
    check_val("req", {31'b0, req}, {31'b0, x_req});
    check_val("stall", {31'b0, stall}, {31'b0, x_req & !ready});
    if (x_req) begin
      check_val("addr", dc_addr, x_a);
      check_val("wdata", dc_wdata, x_d);
      check_val("wstrb", {28'b0, dc_wstrb}, {28'b0, x_s});
      check_val("we", {31'b0, dc_we}, {31'b0, x_we});
    end
    check_val("misalign", {31'b0, mis}, {31'b0, e_mis});
    check_val("wb_op_c", wb_op_c, e_op);
    check_val("wb_ctl", {22'b0, wb_waddr, wb_reg_we, wb_mtype, wb_width},
              {22'b0, e_wa, e_rwe, e_mt, e_w});
    check_val("state", {30'b0, st}, {30'b0, x_st});
    prev_bk = bk;
    if (bk) begin
      e_mis = 0;
    end else begin
      acc = x_req & ready;
      cap = !flush && ((m_pend && !m_drop && acc) || (!m_pend && ex_valid && (!ex_mtype || acc)));
      e_op = cap ? ex_op_c : 0; e_wa = cap ? ex_waddr : 0; e_rwe = cap & ex_reg_we;
      e_mt = cap & ex_mtype; e_w = cap ? ex_width : 2'b00;
      e_mis = !m_pend && mem && !ok && !flush;
      if (m_pend) begin
        if (acc) m_pend = 0;
        else if (flush) m_drop = 1;
      end else if (x_req && !ready) begin
        m_pend = 1; m_drop = flush; m_addr = x_a; m_wdata = x_d; m_wstrb = x_s; m_we = x_we;
      end
      if (!m_pend) m_drop = 0;
    end
    @(posedge clk);
    #1;
  endtask

  int stall_cnt;

  initial begin
    rst = 1; ready = 0; flush = 0; bk = 0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req", {31'b0, req}, 32'd0);
    check_val("rst_wb", {wb_op_c[31:10], wb_waddr, wb_reg_we, wb_mtype, wb_width}, 32'd0);
    rst = 0;

    // SH 0x1234ABCD to 0x102, accepted at once
    ready = 1;
    drive(1, 1, 1, W_HALF, 32'h102, 32'h1234_ABCD, 5'd3, 0);
    #2;
    check_val("sh_wdata", dc_wdata, 32'hABCD_ABCD);
    check_val("sh_wstrb", {28'b0, dc_wstrb}, 32'hC);
    step();
    drive(1, 0, 0, W_WORD, 32'h55, 0, 5'd7, 1);   // ADD result 0x55
    #2;
    check_val("sh_wb_mtype", {31'b0, wb_mtype}, 32'd1);
    step();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    #2;
    check_val("add_wb", wb_op_c, 32'h55);
    step();

    // LW at 0x200 with ready low for 3 cycles
    ready = 0; stall_cnt = 0;
    drive(1, 1, 0, W_WORD, 32'h200, 0, 5'd9, 1);
    for (int i = 0; i < 3; i++) begin
      #2; if (stall === 1'b1) stall_cnt++;
      step();
    end
    ready = 1;
    #2; if (stall === 1'b1) stall_cnt++;
    step();
    check_val("lw_stall_cycles", stall_cnt, 3);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    step();

    // LW at 0x201: misaligned
    drive(1, 1, 0, W_WORD, 32'h201, 0, 5'd4, 1);
    step();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    #2;
    check_val("misalign_pulse", {31'b0, mis}, 32'd1);
    step();

    // SB stalled, flushed in WAIT, accepted two cycles later
    ready = 0;
    drive(1, 1, 1, W_BYTE, 32'h303, 32'h77, 5'd0, 0);
    step();
    flush = 1; step(); flush = 0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    #2;
    check_val("drain_state", {30'b0, st}, {30'b0, DRAIN});
    step(); step();
    ready = 1; step();

    // bk for 2 cycles during WAIT
    ready = 0;
    drive(1, 1, 0, W_HALF, 32'h41E, 0, 5'd12, 1);
    step();
    bk = 1; step(); step(); bk = 0;
    ready = 1; step();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    step();

    // reset in the middle of WAIT
    ready = 0;
    drive(1, 1, 0, W_WORD, 32'h500, 0, 5'd2, 1);
    step();
    rst = 1;
    #2;
    check_val("rst_wait_req", {31'b0, req}, 32'd0);
    check_val("rst_wait_state", {30'b0, st}, {30'b0, IDLE});
    check_val("rst_wait_out", {wb_op_c[31:8], wb_reg_we, wb_mtype, stall, mis, wb_width, 2'b0}, 32'd0);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();

    // random traffic; upstream holds EX/MEM while stalled or backed off
    for (int n = 0; n < 3000; n++) begin
      if (!(prev_bk || (m_pend && !m_drop))) begin
        if (m_drop) drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
        else drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                   $urandom, $urandom, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)));
      end
      ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 11) == 0;
      bk    = $urandom_range(0, 9) == 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the core, located between the EX/MEM pipeline register and the WB stage. It sends load and store requests to the Dcache through a req/ready handshake and generates store byte-strobes and lane-replicated write data. It detects misaligned accesses and holds requests that are outstanding across stalls and flushes. It registers the memwb_* bundle that WB consumes, and raises a stall toward flow control while a Dcache request has not been accepted.

## Interface
- No parameters. XLEN is fixed at 32.
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- exmem_valid_i  in  1  EX/MEM slot holds a valid instruction
- exmem_op_c_i  in  32  ALU result; byte address for memory operations
- exmem_store_data_i  in  32  store source register value
- exmem_reg_waddr_i  in  5  destination register
- exmem_reg_we_i  in  1  register write enable
- exmem_mtype_i  in  1  instruction accesses Dcache
- exmem_we_i  in  1  1 = store, 0 = load (valid only when mtype = 1)
- exmem_width_i  in  2  01 = byte, 10 = half, 11 = word, 00 = illegal
- Dcache_req_o  out  1  request valid
- Dcache_we_o  out  1  store request
- Dcache_addr_o  out  32  byte address
- Dcache_wdata_o  out  32  lane-replicated store data
- Dcache_wstrb_o  out  4  byte enables
- Dcache_ready_i  in  1  request accepted this cycle
- mem_stall_o  out  1  to fc; stalls IF through EX/MEM
- misalign_o  out  1  one-cycle exception pulse to fc
- fc_flush_mem_i  in  1  load a bubble into memwb
- fc_bk_mem_i  in  1  back-and-keep: hold memwb and issue no request
- memwb_op_c_o, memwb_reg_waddr_o, memwb_reg_we_o, memwb_mtype_o, memwb_width_o  out  32/5/1/1/2  registered bundle to WB

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; EX/MEM is held by the stall.
  - DRAIN: outstanding request whose instruction was flushed; the result is discarded.
- Memory operations:
  - Eligible operation: exmem_valid_i & exmem_mtype_i & aligned & width != 00.
  - In IDLE, an eligible operation drives Dcache_req_o high combinationally from the exmem inputs.
  - Alignment: byte is always aligned; half requires addr[0] = 0; word requires addr[1:0] = 00.
- Store data and strobes:
  - Byte: wdata = {4{d[7:0]}}, wstrb = 0001 << addr[1:0].
  - Half: wdata = {2{d[15:0]}}, wstrb = 0011 << addr[1:0].
  - Word: wdata = d, wstrb = 1111.
  - Load: wstrb = 0000.
- Acceptance and state changes:
  - Acceptance occurs on Dcache_req_o & Dcache_ready_i.
  - Not accepted in IDLE: latch addr, wdata, wstrb and we, then go to WAIT. In WAIT and DRAIN the Dcache_* outputs come from the latch.
  - Accepted in IDLE or WAIT: the memwb bundle captures the instruction (mtype = 1) and the FSM goes to IDLE.
  - Accepted in DRAIN: memwb captures a bubble and the FSM goes to IDLE.
- mem_stall_o = Dcache_req_o & ~Dcache_ready_i.
- Non-memory instructions pass to memwb with a latency of 1 cycle and no stall.
- Misaligned access or width 00:
  - No request is issued.
  - misalign_o pulses for 1 cycle.
  - memwb captures a bubble.
- Bubble: all memwb outputs are 0.
- Priority: fc_bk_mem_i > fc_flush_mem_i > normal operation.
  - bk: memwb holds its value, Dcache_req_o is forced to 0, the FSM holds its state, and Dcache_ready_i is ignored.
  - flush in IDLE: memwb captures a bubble.
  - flush in WAIT: the FSM goes to DRAIN. The request stays asserted until it is accepted, so stores are never silently dropped.
- Loads: the Dcache returns data right-justified. WB performs sign extension using memwb_width_o.

## Timing
- Reset:
  - All memwb outputs are 0.
  - FSM is in IDLE.
  - Latch is 0.
  - Dcache_req_o, misalign_o and mem_stall_o are 0.
  - Reset asserted mid-WAIT abandons the request immediately.
- Latency:
  - memwb updates on the edge where the request is accepted.
  - Load data reaches WB on the following cycle, qualified by fc_Dcache_data_valid.
- Request stability: once asserted, Dcache_req_o and its address, data and strobe stay stable until acceptance. The only exceptions are bk and reset.
- Simultaneous flush and acceptance in IDLE: the request is accepted and memwb captures a bubble. Stores are therefore still performed.
- Back-to-back memory operations: accepted one per cycle when Dcache_ready_i stays high.

## Structure
- Shared package core_pkg holds:
  - width encodings (W_BYTE, W_HALF, W_WORD)
  - mem_state_e {IDLE, WAIT, DRAIN}
  - a memwb bundle struct
- One sub-module, mem_store_align, is a combinational unit:
  - inputs: width, addr[1:0], data
  - outputs: wdata, wstrb, misalign

## Test plan
- SH of 0x1234ABCD to addr 0x102, ready high → req with wdata 0xABCDABCD, wstrb 1100; memwb_mtype = 1 the next cycle; no stall.
- LW at 0x200 with ready low for 3 cycles → mem_stall_o high for exactly 3 cycles; address stable; state IDLE→WAIT→IDLE.
- LW at 0x201 → misalign_o pulses 1 cycle; Dcache_req_o stays 0; memwb_reg_we_o = 0.
- SB in WAIT with fc_flush_mem_i for 1 cycle, ready after 2 more cycles → request still accepted; memwb bubble; state DRAIN→IDLE.
- fc_bk_mem_i during WAIT for 2 cycles → req drops to 0 and memwb holds its value; after bk, the identical request is reasserted.
- ADD result 0x55 with reg_we = 1 → memwb_op_c_o = 0x55 one cycle later; then rst pulsed mid-WAIT → all outputs 0, state IDLE.
